// File: rtl/fb_pkg.sv
// Shared constants and enumerations for the frame-buffer port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_pkg;

    localparam int FB_ADDR_W = 17;  // 320x240 = 76800 words
    localparam int FB_DATA_W = 12;  // RGB444

    // Which requester owns the RAM slot issued in a given cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CAM,
        OWN_CPU
    } owner_e;

    // CPU access sequencer.
    typedef enum logic [2:0] {
        C_IDLE,
        C_WR,
        C_RD1,
        C_RD2,
        C_DONE
    } cpu_state_e;

endpackage

// File: rtl/fb_prio_sel.sv
// Three-way fixed-priority select (VGA > camera > CPU) with a CPU aging override.
// Latency: purely combinational.
// Backpressure: losers simply see no grant; at most one grant bit is ever set.
//
// Ports: vga_req_i/cam_req_i/cpu_req_i raw requests, cpu_elig_i CPU sequencer is
// idle, age_hit_i CPU has lost enough cycles to outrank the camera,
// gnt_o one-hot grant {cpu, cam, vga}.
module fb_prio_sel (
    input  logic       vga_req_i,
    input  logic       cam_req_i,
    input  logic       cpu_req_i,
    input  logic       cpu_elig_i,
    input  logic       age_hit_i,
    output logic [2:0] gnt_o
);

    logic cpu_want;

    always_comb begin
        cpu_want = cpu_req_i && cpu_elig_i;
        gnt_o    = 3'b000;
        if (vga_req_i) begin
            gnt_o[0] = 1'b1;            // display refresh is never overridden
        end else if (cpu_want && age_hit_i) begin
            gnt_o[2] = 1'b1;            // starved CPU jumps the camera
        end else if (cam_req_i) begin
            gnt_o[1] = 1'b1;
        end else if (cpu_want) begin
            gnt_o[2] = 1'b1;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA prefetch, camera writer and CPU.
// Latency: grant G, RAM issue G+1, read data / CPU read ack G+2, CPU write ack G+1.
// Backpressure: grants are combinational; a requester without grant retries next cycle.
//
// Ports: vga_* read port, cam_* write port, cpu_* held-request port with ack pulse,
// ram_* registered RAM interface (1-cycle read latency), stat_* camera stall counter.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 8,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cam_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_cam_stall
);

    localparam int                AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    cpu_state_e        state_q, state_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    // Read tracking: *_rd marks a read in flight, *_vga is the owner tag (1 = VGA, 0 = CPU).
    logic              s1_rd_q, s1_rd_d, s1_vga_q, s1_vga_d;
    logic              s2_rd_q, s2_vga_q;
    logic [2:0]        gnt_raw;
    logic              cpu_elig, age_hit;
    owner_e            win;

    assign cpu_elig = (state_q == C_IDLE);
    assign age_hit  = (age_q == AGE_MAX);

    fb_prio_sel u_prio (
        .vga_req_i (vga_req),
        .cam_req_i (cam_req),
        .cpu_req_i (cpu_req),
        .cpu_elig_i(cpu_elig),
        .age_hit_i (age_hit),
        .gnt_o     (gnt_raw)
    );

    // Grants are suppressed while reset is held so every output reads 0 in reset.
    always_comb begin
        win = OWN_NONE;
        if (!rst) begin
            case (gnt_raw)
                3'b001:  win = OWN_VGA;
                3'b010:  win = OWN_CAM;
                3'b100:  win = OWN_CPU;
                default: win = OWN_NONE;
            endcase
        end
    end

    assign vga_gnt = (win == OWN_VGA);
    assign cam_gnt = (win == OWN_CAM);

    // Issue stage: address/data hold their last value on idle cycles.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        s1_rd_d     = 1'b0;
        s1_vga_d    = 1'b0;
        case (win)
            OWN_VGA: begin
                ram_en_d   = 1'b1;
                ram_addr_d = vga_addr;
                s1_rd_d    = 1'b1;
                s1_vga_d   = 1'b1;
            end
            OWN_CAM: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = cam_addr;
                ram_wdata_d = cam_wdata;
            end
            OWN_CPU: begin
                ram_en_d    = 1'b1;
                ram_we_d    = cpu_we;
                ram_addr_d  = cpu_addr;
                ram_wdata_d = cpu_wdata;
                s1_rd_d     = !cpu_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (win == OWN_CPU) state_d = cpu_we ? C_WR : C_RD1;
            C_WR:    state_d = C_DONE;
            C_RD1:   state_d = C_RD2;
            C_RD2:   state_d = C_DONE;
            C_DONE:  state_d = C_IDLE;  // gives the master a cycle to drop cpu_req
            default: state_d = C_IDLE;
        endcase
    end

    // Age counts cycles the CPU waited while eligible; VGA wins count too.
    always_comb begin
        age_d = age_q;
        if (win == OWN_CPU) begin
            age_d = '0;
        end else if (cpu_elig && cpu_req && !age_hit) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_comb begin
        stat_d = stat_q;
        if (stat_clr) begin
            stat_d = '0;
        end else if (cam_req && !cam_gnt && (stat_q != STAT_MAX)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            age_q       <= '0;
            stat_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            s1_rd_q     <= 1'b0;
            s1_vga_q    <= 1'b0;
            s2_rd_q     <= 1'b0;
            s2_vga_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            age_q       <= age_d;
            stat_q      <= stat_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            s1_rd_q     <= s1_rd_d;
            s1_vga_q    <= s1_vga_d;
            s2_rd_q     <= s1_rd_q;
            s2_vga_q    <= s1_vga_q;
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign stat_cam_stall = stat_q;

    // Read data comes straight from the RAM's output register, gated by the
    // owner tag so the idle bus stays at zero.
    assign vga_rvalid = s2_rd_q && s2_vga_q;
    assign vga_rdata  = vga_rvalid ? ram_rdata : '0;
    assign cpu_ack    = (state_q == C_WR) || (state_q == C_RD2);
    assign cpu_rdata  = (s2_rd_q && !s2_vga_q) ? ram_rdata : '0;

endmodule
